// File: rtl/mips_regfile_sb.sv
// Two-write-port MIPS register file with a per-register busy scoreboard for long-latency results.
// Define REGFILE_BYPASS_EN to make same-cycle writes visible to the read ports and to issue.
module mips_regfile_sb #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NREAD = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   we0,
   input  logic [AW-1:0]          wa0,
   input  logic [WIDTH-1:0]       wd0,
   input  logic                   we1,
   input  logic [AW-1:0]          wa1,
   input  logic [WIDTH-1:0]       wd1,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_addr,
   output logic                   iss_ready,
   output logic [AW:0]            pend_cnt
);

   localparam int unsigned NREG = 2**AW;

   logic [WIDTH-1:0] mem_q [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [AW:0]      pend_q, pend_d;
   logic             set_en, inc, dec;
   logic             wr0_en, wr1_en;
   logic [AW-1:0]    ra;
   logic [WIDTH-1:0] rdat;
   logic             rbusy;

`ifdef REGFILE_BYPASS_EN
   assign iss_ready = (iss_addr == '0) | ~busy_q[iss_addr] | (we1 && (wa1 == iss_addr));
`else
   assign iss_ready = (iss_addr == '0) | ~busy_q[iss_addr];
`endif

   assign set_en = iss_valid && iss_ready && (iss_addr != '0);
   assign wr0_en = we0 && (wa0 != '0);
   assign wr1_en = we1 && (wa1 != '0) && !(we0 && (wa0 == wa1));

   // Count only real transitions so clears of idle registers and set-over-clear stay exact.
   assign inc = set_en && !busy_q[iss_addr];
   assign dec = we1 && busy_q[wa1] && !(set_en && (iss_addr == wa1));

   always_comb begin
      busy_d = busy_q;
      if (we1)    busy_d[wa1]      = 1'b0;
      if (set_en) busy_d[iss_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      pend_d = pend_q;
      if (inc && !dec)      pend_d = pend_q + (AW+1)'(1);
      else if (dec && !inc) pend_d = pend_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < NREG; k++) mem_q[k] <= '0;
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         if (wr0_en) mem_q[wa0] <= wd0;
         if (wr1_en) mem_q[wa1] <= wd1;
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

   assign pend_cnt = pend_q;

   // Port 0 is applied last so it overrides port 1 on an address collision.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rdat    = '0;
      rbusy   = 1'b0;
      for (int unsigned i = 0; i < NREAD; i++) begin
         ra    = rd_addr[i*AW +: AW];
         rdat  = mem_q[ra];
         rbusy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
         if (we1 && (wa1 == ra)) begin
            rdat  = wd1;
            rbusy = 1'b0;
         end
         if (we0 && (wa0 == ra)) rdat = wd0;
`endif
         if ((ra == '0) || !reset_n) begin
            rdat  = '0;
            rbusy = 1'b0;
         end
         rd_data[i*WIDTH +: WIDTH] = rdat;
         rd_busy[i]                = rbusy;
      end
   end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed-vector bench for mips_regfile_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_mips_regfile_sb;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREAD = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic [NREAD*AW-1:0]    rd_addr;
   logic [NREAD*WIDTH-1:0] rd_data;
   logic [NREAD-1:0]       rd_busy;
   logic                   we0, we1, iss_valid, iss_ready;
   logic [AW-1:0]          wa0, wa1, iss_addr;
   logic [WIDTH-1:0]       wd0, wd1;
   logic [AW:0]            pend_cnt;

   mips_regfile_sb #(.WIDTH(WIDTH), .AW(AW), .NREAD(NREAD)) dut (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready), .pend_cnt(pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic we0; logic [4:0] wa0; logic [31:0] wd0;
      logic we1; logic [4:0] wa1; logic [31:0] wd1;
      logic iv;  logic [4:0] ia;
      logic [4:0] ra0; logic [4:0] ra1;
      logic [31:0] e0; logic [31:0] e1; logic [1:0] eb; logic er; logic [5:0] ep;
   } vec_t;

   localparam int NV = 24;
   vec_t tv [NV];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
      we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
      iss_valid = v.iv; iss_addr = v.ia;
      rd_addr = {v.ra1, v.ra0};
   endtask

   task automatic check_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [1:0] eb, input logic er, input logic [5:0] ep);
      check({tag, ".rd0"},   64'(rd_data[31:0]),  64'(e0));
      check({tag, ".rd1"},   64'(rd_data[63:32]), 64'(e1));
      check({tag, ".busy"},  64'(rd_busy),        64'(eb));
      check({tag, ".ready"}, 64'(iss_ready),      64'(er));
      check({tag, ".pend"},  64'(pend_cnt),       64'(ep));
   endtask

   function automatic vec_t idle(input logic [4:0] ia, input logic [4:0] ra0, input logic [4:0] ra1);
      vec_t v;
      v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ia, ra0, ra1, 32'd0, 32'd0, 2'b00, 1'b1, 6'd0};
      return v;
   endfunction

   initial begin
      //          we0 wa0   wd0            we1 wa1   wd1       iv   ia     ra0    ra1    e0                       e1                    eb                    er              ep
      tv[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd0,  5'd31, 32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};
      tv[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 0,  BYP ? 32'hDEADBEEF : 0, 2'b00,             1'b1,           6'd0};
      tv[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF,            32'h0,                2'b00,                1'b1,           6'd0};
      tv[3]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,  1'b0, 5'd0,  5'd7,  5'd7,  BYP ? 32'h11 : 0,        BYP ? 32'h11 : 0,     2'b00,                1'b1,           6'd0};
      tv[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd7,  5'd0,  32'h11,                  32'h0,                2'b00,                1'b1,           6'd0};
      tv[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd0,  5'd7,  32'h0,                   32'h11,               2'b00,                1'b1,           6'd0};
      tv[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd9,  5'd9,  5'd0,  32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};
      tv[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd9,  5'd9,  5'd9,  32'h0,                   32'h0,                2'b11,                1'b0,           6'd1};
      tv[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h1234,1'b0, 5'd9,  5'd9,  5'd0,  BYP ? 32'h1234 : 0,      32'h0,                BYP ? 2'b00 : 2'b01,  BYP,            6'd1};
      tv[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd9,  5'd9,  5'd0,  32'h1234,                32'h0,                2'b00,                1'b1,           6'd0};
      tv[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd3,  5'd3,  5'd0,  32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};
      tv[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h33,  1'b1, 5'd3,  5'd3,  5'd0,  BYP ? 32'h33 : 0,        32'h0,                BYP ? 2'b00 : 2'b01,  BYP,            6'd1};
      tv[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd3,  5'd3,  5'd0,  32'h33,                  32'h0,                BYP ? 2'b01 : 2'b00,  !BYP,           BYP ? 6'd1 : 6'd0};
      tv[13] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h44,  1'b0, 5'd3,  5'd0,  5'd3,  32'h0,                   BYP ? 32'h44 : 32'h33, 2'b00,               1'b1,           BYP ? 6'd1 : 6'd0};
      tv[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd3,  5'd3,  5'd0,  32'h44,                  32'h0,                2'b00,                1'b1,           6'd0};
      tv[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'hAA, 1'b0, 5'd0,  5'd10, 5'd0,  BYP ? 32'hAA : 0,        32'h0,                2'b00,                1'b1,           6'd0};
      tv[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd10, 5'd0,  32'hAA,                  32'h0,                2'b00,                1'b1,           6'd0};
      tv[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd12, 5'd12, 5'd13, 32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};
      tv[18] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h55, 1'b1, 5'd13, 5'd12, 5'd13, BYP ? 32'h55 : 0,        32'h0,                BYP ? 2'b00 : 2'b01,  1'b1,           6'd1};
      tv[19] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd13, 5'd12, 5'd13, 32'h55,                  32'h0,                2'b10,                1'b0,           6'd1};
      tv[20] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd13, 32'h66, 1'b0, 5'd13, 5'd12, 5'd13, 32'h55,                  BYP ? 32'h66 : 0,     BYP ? 2'b00 : 2'b10,  BYP,            6'd1};
      tv[21] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd13, 5'd12, 5'd13, 32'h55,                  32'h66,               2'b00,                1'b1,           6'd0};
      tv[22] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd0,  5'd0,  5'd0,  32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};
      tv[23] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  5'd0,  5'd0,  32'h0,                   32'h0,                2'b00,                1'b1,           6'd0};

      reset_n = 1'b0;
      drive(idle(5'd0, 5'd0, 5'd0));
      repeat (2) @(negedge clk);
      #1 check_all("in_reset", 32'h0, 32'h0, 2'b00, 1'b1, 6'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         drive(idle(5'(a), 5'(a), 5'(31 - a)));
         #1;
         check($sformatf("rst_rd0[%0d]", a), 64'(rd_data[31:0]), 64'h0);
         check($sformatf("rst_rd1[%0d]", a), 64'(rd_data[63:32]), 64'h0);
         check($sformatf("rst_busy[%0d]", a), 64'(rd_busy), 64'h0);
         check($sformatf("rst_ready[%0d]", a), 64'(iss_ready), 64'h1);
      end
      check("rst_pend", 64'(pend_cnt), 64'h0);

      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         drive(tv[k]);
         #1 check_all($sformatf("vec%0d", k), tv[k].e0, tv[k].e1, tv[k].eb, tv[k].er, tv[k].ep);
      end

      // Two pending ops with data in the same registers, then an asynchronous mid-cycle reset.
      @(negedge clk);
      drive(idle(5'd4, 5'd0, 5'd0));
      iss_valid = 1'b1; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h4444;
      @(negedge clk);
      drive(idle(5'd6, 5'd0, 5'd0));
      iss_valid = 1'b1; we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h6666;
      @(negedge clk);
      drive(idle(5'd4, 5'd4, 5'd6));
      #1 check_all("pre_rst", 32'h4444, 32'h6666, 2'b11, 1'b0, 6'd2);
      #1 reset_n = 1'b0;
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hABCD;
      #1 check_all("async_rst", 32'h0, 32'h0, 2'b00, 1'b1, 6'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(idle(5'd6, 5'd4, 5'd6));
      #1 check_all("post_rst", 32'h0, 32'h0, 2'b00, 1'b1, 6'd0);
      @(negedge clk);
      #1 check_all("post_rst2", 32'h0, 32'h0, 2'b00, 1'b1, 6'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
Parametrised register file for the next MIPS core generation.
- NREAD combinational read ports; two write ports: port 0 for ALU/WB results, port 1 for long-latency units such as multiply/divide or load return.
- Write-to-read bypass on both write ports.
- Per-register scoreboard (busy bits) so decode can stall on registers that long-latency operations have not yet written.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
WIDTH, 32, data width in bits
AW, 5, address width; register count = 2**AW
NREAD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
rd_addr  in  NREAD*AW  read addresses, port i at bits [i*AW +: AW]
rd_data  out  NREAD*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH]
rd_busy  out  NREAD  register on read port i still has a write pending
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (long-latency)
wa1  in  AW  write address, port 1
wd1  in  WIDTH  write data, port 1
iss_valid  in  1  long-latency op issued; mark iss_addr busy
iss_addr  in  AW  destination register of the issued op
iss_ready  out  1  iss_addr can accept a new pending write
pend_cnt  out  AW+1  number of busy registers

Behaviour:
- Clock and reset: reset_n, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset: all 2**AW entries cleared to 0; all busy bits cleared; pend_cnt=0. rd_data is combinational and reads 0 during reset. Reset mid-operation discards all pending state immediately.
- Register 0:
  - Hardwired zero; writes to it are ignored on both ports.
  - Never marked busy.
  - Reads of address 0 return 0 and rd_busy=0.
- Writes: take effect at posedge when weN=1.
  - Same-cycle writes to the same address: port 0 wins; port 1 data is dropped, but its scoreboard clear still applies.
- Reads: combinational, zero latency. Priority for port i with address ra≠0:
  1. we0 && wa0==ra → wd0
  2. we1 && wa1==ra → wd1
  3. otherwise the stored value
- Scoreboard:
  - busy[a] is set at posedge when iss_valid && iss_ready && iss_addr≠0.
  - busy[a] is cleared at posedge when we1 && wa1==a.
  - Set and clear to the same address in the same cycle: set wins. The new op is pending and the old result is written.
  - Writes on port 0 never affect busy bits.
- iss_ready = (iss_addr==0) | ~busy[iss_addr] | (we1 && wa1==iss_addr). When iss_valid=1 and iss_ready=0, the issue is ignored and the upstream logic must hold it.
- rd_busy[i] = busy[ra] & ~(we1 && wa1==ra). A same-cycle port-1 write releases the stall through the bypass.
- pend_cnt: registered; equals the popcount of the busy bits after each edge. Incremented and decremented by the set/clear events; no recount. A simultaneous set and clear on different addresses leaves the count unchanged.
- Port-1 write to a non-busy register: data is written, scoreboard unchanged, no error.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: read bypass as described above; rd_busy is masked by a same-cycle we1.
- Undefined:
  - Reads return the stored value only; a write becomes visible the cycle after the edge.
  - rd_busy = busy[ra], with no mask.
  - iss_ready drops its we1 term.
  - Scoreboard set/clear semantics are otherwise identical.

Test Plan:
- Reset, then read every address on all ports → all rd_data=0, rd_busy=0, pend_cnt=0, iss_ready=1.
- we0=1, wa0=5, wd0=0xDEADBEEF with rd_addr port0=5 in the same cycle → rd_data=0xDEADBEEF combinationally (bypass on); next cycle reads 0xDEADBEEF with we0=0.
- we0 and we1 both to address 7 with wd0=0x11, wd1=0x22 → reg7=0x11 after the edge; a write to address 0 with 0xFFFFFFFF → reg0 still reads 0.
- Issue to 9 → busy[9]=1, pend_cnt=1, iss_ready=0 for iss_addr=9. A second issue to 9 is ignored. we1 to 9 with 0x1234 while rd_addr=9 → rd_busy=0, rd_data=0x1234; next cycle pend_cnt=0.
- Same-cycle iss_valid to 3 and we1 to 3 while busy[3]=1 → busy[3] remains 1 and pend_cnt is unchanged; the reg3 value is updated.
- Issue to 4 and 6, then assert reset_n=0 mid-cycle → busy bits and pend_cnt clear asynchronously; regs 4 and 6 read 0.
